// File: rtl/pipe_stage_hs_if.sv
// Valid/ready handshake bundle carrying a data payload and a control vector.
interface pipe_stage_hs_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 4
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with a 2-entry skid buffer, flush and a
// saturating stall counter. in_ready and all out_* signals come straight from flops.
module pipe_stage_hs #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_hs_if.slave       in_hs,
  pipe_stage_hs_if.master      out_hs,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] main_data_q;
  logic [CTRL_WIDTH-1:0] main_ctrl_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q;
  logic                  out_valid_q;
  logic                  in_ready_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;

  logic push;
  logic pop;
  logic stalled;

  assign push    = in_hs.valid & in_ready_q;
  assign pop     = out_valid_q & out_hs.ready;
  assign stalled = out_valid_q & ~out_hs.ready;

  // main_ctrl_q is zeroed whenever the stage empties, so bubbles carry no control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else if (flush) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          in_ready_q <= 1'b1;
          if (push) begin
            state_q     <= StOne;
            main_data_q <= in_hs.data;
            main_ctrl_q <= in_hs.ctrl;
            out_valid_q <= 1'b1;
          end
        end
        StOne: begin
          if (push && pop) begin
            main_data_q <= in_hs.data;
            main_ctrl_q <= in_hs.ctrl;
          end else if (push) begin
            state_q     <= StFull;
            skid_data_q <= in_hs.data;
            skid_ctrl_q <= in_hs.ctrl;
            in_ready_q  <= 1'b0;
          end else if (pop) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            out_valid_q <= 1'b0;
          end
        end
        StFull: begin
          if (pop) begin
            state_q     <= StOne;
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StEmpty;
          main_ctrl_q <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Only reset clears the counter; flush leaves the performance history intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stalled && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign in_hs.ready  = in_ready_q;
  assign out_hs.valid = out_valid_q;
  assign out_hs.data  = main_data_q;
  assign out_hs.ctrl  = main_ctrl_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs: directed scenarios plus randomized traffic
// against a queue-based occupancy model; a 3-bit-counter twin checks saturation.
module tb_pipe_stage_hs;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] stall_cnt;
  logic [2:0]  stall_cnt3;

  pipe_stage_hs_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in_bus ();
  pipe_stage_hs_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_bus ();
  pipe_stage_hs_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in_bus3 ();
  pipe_stage_hs_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_bus3 ();

  pipe_stage_hs #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_hs    (in_bus),
    .out_hs   (out_bus),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_hs #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_hs    (in_bus3),
    .out_hs   (out_bus3),
    .stall_cnt(stall_cnt3)
  );

  assign in_bus3.valid  = in_bus.valid;
  assign in_bus3.data   = in_bus.data;
  assign in_bus3.ctrl   = in_bus.ctrl;
  assign out_bus3.ready = out_bus.ready;

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  beat_t       sb[$];
  int          exp_held;
  logic        exp_in_ready;
  int unsigned exp_stall;
  int unsigned exp_stall3;
  logic        p_v, p_r, p_f, p_rs;
  bit          mon_en = 1'b0;
  logic        prev_hold = 1'b0;
  beat_t       prev_beat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the effect of the clock edge just taken, using the inputs held during it.
  task automatic step_model();
    bit pop_e;
    bit push_e;
    pop_e  = (exp_held > 0) && p_r;
    push_e = p_v && exp_in_ready;
    if (p_rs) begin
      exp_held     = 0;
      exp_stall    = 0;
      exp_stall3   = 0;
      exp_in_ready = 1'b0;
      sb.delete();
    end else begin
      if (exp_held > 0 && !p_r) begin
        if (exp_stall < 65535) exp_stall++;
        if (exp_stall3 < 7) exp_stall3++;
      end
      if (p_f) begin
        exp_held = 0;
        sb.delete();
      end else begin
        exp_held = exp_held + int'(push_e) - int'(pop_e);
      end
      exp_in_ready = (exp_held < 2);
    end
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic r, input logic f, input logic rs);
    @(posedge clk);
    #1;
    step_model();
    in_bus.valid  = v;
    in_bus.data   = d;
    in_bus.ctrl   = c;
    out_bus.ready = r;
    flush         = f;
    rst           = rs;
    if (v && exp_in_ready && !f && !rs) sb.push_back(beat_t'{ctrl: c, data: d});
    p_v  = v;
    p_r  = r;
    p_f  = f;
    p_rs = rs;
  endtask

  // Monitor: inputs and outputs are both stable at the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 64'(out_bus.valid), 64'(exp_held > 0));
      chk("in_ready", 64'(in_bus.ready), 64'(exp_in_ready));
      chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      chk("stall_cnt3", 64'(stall_cnt3), 64'(exp_stall3));
      if (out_bus.valid) begin
        if (prev_hold) begin
          chk("stable_data", 64'(out_bus.data), 64'(prev_beat.data));
          chk("stable_ctrl", 64'(out_bus.ctrl), 64'(prev_beat.ctrl));
        end
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'(1));
        end else begin
          chk("out_data", 64'(out_bus.data), 64'(sb[0].data));
          chk("out_ctrl", 64'(out_bus.ctrl), 64'(sb[0].ctrl));
          if (out_bus.ready) void'(sb.pop_front());
        end
      end else begin
        chk("bubble_ctrl", 64'(out_bus.ctrl), 64'(0));
      end
      prev_hold = out_bus.valid && !out_bus.ready && !flush && !rst;
      prev_beat = {out_bus.ctrl, out_bus.data};
    end
  end

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    in_bus.valid  = 1'b0;
    in_bus.data   = '0;
    in_bus.ctrl   = '0;
    out_bus.ready = 1'b0;
    p_v = 1'b0; p_r = 1'b0; p_f = 1'b0; p_rs = 1'b1;
    exp_held = 0; exp_in_ready = 1'b0; exp_stall = 0; exp_stall3 = 0;

    // Reset
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_in_ready", 64'(in_bus.ready), 64'(0));
    chk("rst_out_valid", 64'(out_bus.valid), 64'(0));
    chk("rst_out_ctrl", 64'(out_bus.ctrl), 64'(0));
    chk("rst_out_data", 64'(out_bus.data), 64'(0));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("in_ready_after_rst", 64'(in_bus.ready), 64'(1));

    // Stream 1..8 at full rate
    for (int i = 1; i <= 9; i++) begin
      cycle(i <= 8, (i <= 8) ? DW'(i) : '0, CW'(i), 1'b1, 1'b0, 1'b0);
      if (i > 1) chk("stream_latency", 64'(out_bus.data), 64'(i - 1));
    end
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Fill skid, hold, then drain
    cycle(1'b1, 32'hA, 4'h1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 4'h2, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", 64'(in_bus.ready), 64'(0));
    chk("full_head", 64'(out_bus.data), 64'hA);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("full_hold", 64'(out_bus.data), 64'hA);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain_second", 64'(out_bus.data), 64'hB);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while full
    cycle(1'b1, 32'hA, 4'hF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 4'hF, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("flush_pre_full", 64'(in_bus.ready), 64'(0));
    cycle(1'b1, 32'hC, 4'hF, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_out_valid", 64'(out_bus.valid), 64'(0));
    chk("flush_out_ctrl", 64'(out_bus.ctrl), 64'(0));
    chk("flush_in_ready", 64'(in_bus.ready), 64'(1));
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Stall counter saturation on the 3-bit twin
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 4'h3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      chk("stall3_sat", 64'(stall_cnt3), 64'((k < 7) ? k : 7));
      chk("stall16", 64'(stall_cnt), 64'(k));
    end

    // Reset while full
    cycle(1'b1, 32'h66, 4'h4, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_full", 64'(in_bus.ready), 64'(0));
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rstfull_valid", 64'(out_bus.valid), 64'(0));
    chk("rstfull_ctrl", 64'(out_bus.ctrl), 64'(0));
    chk("rstfull_stall", 64'(stall_cnt), 64'(0));
    chk("rstfull_stall3", 64'(stall_cnt3), 64'(0));
    chk("rstfull_in_ready", 64'(in_bus.ready), 64'(0));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("rst_hold_in_ready", 64'(in_bus.ready), 64'(0));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("rst_release_in_ready", 64'(in_bus.ready), 64'(1));

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      logic v, r, f, rs;
      v  = ($urandom_range(0, 3) != 0);
      r  = (i % 2000 < 1000) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 63) == 0);
      rs = ($urandom_range(0, 499) == 0);
      cycle(v, DW'($urandom()), CW'($urandom()), r, f, rs);
    end

    repeat (5) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
